// File: rtl/pipelined_control_unit_if.sv
// Control-unit bundle between the ID-stage datapath and the LEGv8 pipelined control unit.
// Master drives the ID-stage fields and flush; slave returns decode, stall and per-stage controls.
interface pipelined_control_unit_if #(
    parameter int OPC_W   = 11,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 2
);
    logic               valid_in;
    logic [OPC_W-1:0]   opcode_in;
    logic [REG_W-1:0]   rn_in;
    logic [REG_W-1:0]   rm_in;
    logic [REG_W-1:0]   rd_in;
    logic               flush_in;

    logic               id_reg2Loc;
    logic               illegal_out;
    logic               stall_out;
    logic               ex_ALUsrc;
    logic [ALUOP_W-1:0] ex_ALUop;
    logic               mem_memRead;
    logic               mem_memWrite;
    logic               mem_branch;
    logic               mem_uncond;
    logic               wb_memtoReg;
    logic               wb_regWrite;
    logic [REG_W-1:0]   wb_rd;

    modport master (
        output valid_in, opcode_in, rn_in, rm_in, rd_in, flush_in,
        input  id_reg2Loc, illegal_out, stall_out,
        input  ex_ALUsrc, ex_ALUop,
        input  mem_memRead, mem_memWrite, mem_branch, mem_uncond,
        input  wb_memtoReg, wb_regWrite, wb_rd
    );

    modport slave (
        input  valid_in, opcode_in, rn_in, rm_in, rd_in, flush_in,
        output id_reg2Loc, illegal_out, stall_out,
        output ex_ALUsrc, ex_ALUop,
        output mem_memRead, mem_memWrite, mem_branch, mem_uncond,
        output wb_memtoReg, wb_regWrite, wb_rd
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// LEGv8 control unit for the 5-stage pipeline: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use stall and branch flush. Define LOAD_USE_STALL_EN to build the load-use hazard detector.
module pipelined_control_unit #(
    parameter int OPC_W   = 11,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 2
) (
    input  logic clk,
    input  logic reset,
    pipelined_control_unit_if.slave bus
);

    localparam logic [OPC_W-1:0] OPC_LDUR = OPC_W'('b11111000010);
    localparam logic [OPC_W-1:0] OPC_STUR = OPC_W'('b11111000000);
    localparam logic [OPC_W-1:0] OPC_ADD  = OPC_W'('b10001011000);
    localparam logic [OPC_W-1:0] OPC_SUB  = OPC_W'('b11001011000);
    localparam logic [OPC_W-1:0] OPC_AND  = OPC_W'('b10001010000);
    localparam logic [OPC_W-1:0] OPC_ORR  = OPC_W'('b10101010000);
    localparam logic [5:0]       PFX_B    = 6'b000101;
    localparam logic [7:0]       PFX_CBZ  = 8'b10110100;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALUOP_PASSB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = ALUOP_W'(2);

    // Control bits that survive past ID; reg2Loc is consumed by the register file read in ID.
    typedef struct packed {
        logic               aluSrc;
        logic [ALUOP_W-1:0] aluOp;
        logic               memRead;
        logic               memWrite;
        logic               branch;
        logic               uncond;
        logic               memtoReg;
        logic               regWrite;
    } ctrl_t;

    ctrl_t            decCtrl;
    logic             decReg2Loc;
    logic             decKnown;
    logic             decUseRn;
    logic             decUseR2;

    ctrl_t            idCtrl;
    logic             stall;

    ctrl_t            exCtrl;
    logic [REG_W-1:0] exRd;
    ctrl_t            memCtrl;
    logic [REG_W-1:0] memRd;
    ctrl_t            wbCtrl;
    logic [REG_W-1:0] wbRd;

    // ------------------------------------------------------------------
    // ID decode
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        decCtrl    = '0;
        decReg2Loc = 1'b0;
        decKnown   = 1'b0;
        decUseRn   = 1'b0;
        decUseR2   = 1'b0;

        if (bus.opcode_in[OPC_W-1 -: 6] == PFX_B) begin
            decKnown       = 1'b1;
            decCtrl.uncond = 1'b1;
            decCtrl.aluOp  = ALUOP_PASSB;
        end else if (bus.opcode_in[OPC_W-1 -: 8] == PFX_CBZ) begin
            decKnown       = 1'b1;
            decReg2Loc     = 1'b1;
            decUseR2       = 1'b1;
            decCtrl.branch = 1'b1;
            decCtrl.aluOp  = ALUOP_PASSB;
        end else begin
            case (bus.opcode_in)
                OPC_LDUR: begin
                    decKnown         = 1'b1;
                    decReg2Loc       = 1'b1;
                    decUseRn         = 1'b1;
                    decCtrl.aluSrc   = 1'b1;
                    decCtrl.aluOp    = ALUOP_ADD;
                    decCtrl.memRead  = 1'b1;
                    decCtrl.memtoReg = 1'b1;
                    decCtrl.regWrite = 1'b1;
                end
                OPC_STUR: begin
                    decKnown         = 1'b1;
                    decReg2Loc       = 1'b1;
                    decUseRn         = 1'b1;
                    decUseR2         = 1'b1;
                    decCtrl.aluSrc   = 1'b1;
                    decCtrl.aluOp    = ALUOP_ADD;
                    decCtrl.memWrite = 1'b1;
                end
                OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR: begin
                    decKnown         = 1'b1;
                    decUseRn         = 1'b1;
                    decUseR2         = 1'b1;
                    decCtrl.aluOp    = ALUOP_RTYPE;
                    decCtrl.regWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // An invalid ID slot is a bubble: nothing it decodes may leave ID.
    assign idCtrl          = bus.valid_in ? decCtrl : '0;
    assign bus.id_reg2Loc  = bus.valid_in & decReg2Loc;
    assign bus.illegal_out = bus.valid_in & ~decKnown;

    // ------------------------------------------------------------------
    // Load-use hazard
    // ------------------------------------------------------------------
`ifdef LOAD_USE_STALL_EN
    logic [REG_W-1:0] readReg2;
    logic             rnHit;
    logic             r2Hit;
    logic             hazard;

    assign readReg2 = decReg2Loc ? bus.rd_in : bus.rm_in;
    assign rnHit    = decUseRn & (bus.rn_in == exRd);
    assign r2Hit    = decUseR2 & (readReg2 == exRd);
    // XZR reads as zero and is never really written, so a load into it can't hazard.
    assign hazard   = bus.valid_in & exCtrl.memRead & (exRd != {REG_W{1'b1}}) & (rnHit | r2Hit);
    // A flush already squashes ID, so holding IF/ID in that cycle would only lose the branch target fetch.
    assign stall    = hazard & ~bus.flush_in;
`else
    logic unusedHazardInputs;

    assign unusedHazardInputs = ^{bus.rn_in, bus.rm_in, decUseRn, decUseR2};
    assign stall              = 1'b0;
`endif

    assign bus.stall_out = stall;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    // NOTE: pipeline state uses non-blocking assignments so every stage samples the previous stage's pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exCtrl <= '0;
            exRd   <= '0;
        end else if (bus.flush_in || stall) begin
            exCtrl <= '0;
            exRd   <= '0;
        end else begin
            exCtrl <= idCtrl;
            exRd   <= bus.valid_in ? bus.rd_in : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memCtrl <= '0;
            memRd   <= '0;
        end else if (bus.flush_in) begin
            memCtrl <= '0;
            memRd   <= '0;
        end else begin
            memCtrl <= exCtrl;
            memRd   <= exRd;
        end
    end

    // The branch resolving in MEM is itself committed; only younger instructions are squashed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbCtrl <= '0;
            wbRd   <= '0;
        end else begin
            wbCtrl <= memCtrl;
            wbRd   <= memRd;
        end
    end

    assign bus.ex_ALUsrc    = exCtrl.aluSrc;
    assign bus.ex_ALUop     = exCtrl.aluOp;
    assign bus.mem_memRead  = memCtrl.memRead;
    assign bus.mem_memWrite = memCtrl.memWrite;
    assign bus.mem_branch   = memCtrl.branch;
    assign bus.mem_uncond   = memCtrl.uncond;
    assign bus.wb_memtoReg  = wbCtrl.memtoReg;
    assign bus.wb_regWrite  = wbCtrl.regWrite;
    assign bus.wb_rd        = wbRd;

    // EX-only fields are consumed before MEM and memory-only fields before WB.
    logic unusedLateFields;
    assign unusedLateFields = ^{memCtrl.aluSrc, memCtrl.aluOp, wbCtrl.aluSrc, wbCtrl.aluOp,
                                wbCtrl.memRead, wbCtrl.memWrite, wbCtrl.branch, wbCtrl.uncond};

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed self-checking bench for pipelined_control_unit: decode table, stage latency,
// load-use stall (both builds), flush and asynchronous reset.
module tb_pipelined_control_unit;

    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;
    localparam logic [10:0] ADD  = 11'b10001011000;
    localparam logic [10:0] SUB  = 11'b11001011000;
    localparam logic [10:0] ANDI = 11'b10001010000;
    localparam logic [10:0] ORR  = 11'b10101010000;
    localparam logic [10:0] CBZ  = 11'b10110100101;
    localparam logic [10:0] BR   = 11'b00010111111;
    localparam logic [10:0] BAD  = 11'b11111111111;

`ifdef LOAD_USE_STALL_EN
    localparam logic STALL_EN = 1'b1;
`else
    localparam logic STALL_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   passes;

    pipelined_control_unit_if bus ();

    pipelined_control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected bundle bits: {reg2Loc, ALUsrc, ALUop[1:0], memRead, memWrite, branch, uncond, memtoReg, regWrite}
    typedef struct {
        logic [10:0] opc;
        logic [9:0]  bundle;
        logic        ill;
        string       name;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [10:0] opc, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [4:0] rd);
        bus.valid_in  = v;
        bus.opcode_in = opc;
        bus.rn_in     = rn;
        bus.rm_in     = rm;
        bus.rd_in     = rd;
    endtask

    task automatic idle();
        drive(1'b0, 11'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_reset();
        logic [13:0] got;
        got = {bus.ex_ALUsrc, bus.ex_ALUop, bus.mem_memRead, bus.mem_memWrite, bus.mem_branch,
               bus.mem_uncond, bus.wb_memtoReg, bus.wb_regWrite, bus.wb_rd};
        checks++;
        if (got !== 14'd0) $display("FAIL reset_state outputs: got %b expected %b", got, 14'd0);
        else passes++;
        checks++;
        if ({bus.stall_out, bus.illegal_out, bus.id_reg2Loc} !== 3'b000)
            $display("FAIL reset_state id: got %b expected 000",
                     {bus.stall_out, bus.illegal_out, bus.id_reg2Loc});
        else passes++;
    endtask

    task automatic test_decode();
        vec_t vecs[10];
        vecs[0] = '{LDUR, 10'b1100100011, 1'b0, "ldur"};
        vecs[1] = '{STUR, 10'b1100010000, 1'b0, "stur"};
        vecs[2] = '{ADD,  10'b0010000001, 1'b0, "add"};
        vecs[3] = '{SUB,  10'b0010000001, 1'b0, "sub"};
        vecs[4] = '{ANDI, 10'b0010000001, 1'b0, "and"};
        vecs[5] = '{ORR,  10'b0010000001, 1'b0, "orr"};
        vecs[6] = '{CBZ,  10'b1001001000, 1'b0, "cbz"};
        vecs[7] = '{BR,   10'b0001000100, 1'b0, "b"};
        vecs[8] = '{BAD,  10'b0000000000, 1'b1, "illegal_ones"};
        vecs[9] = '{11'b11111000011, 10'b0000000000, 1'b1, "illegal_near_ldur"};
        for (int i = 0; i < 10; i++) begin
            logic [4:0] rd;
            rd = 5'(i + 10);
            drive(1'b1, vecs[i].opc, 5'd1, 5'd2, rd);
            #1;
            checks++;
            if ({bus.id_reg2Loc, bus.illegal_out} !== {vecs[i].bundle[9], vecs[i].ill})
                $display("FAIL decode_%s id: got %b expected %b", vecs[i].name,
                         {bus.id_reg2Loc, bus.illegal_out}, {vecs[i].bundle[9], vecs[i].ill});
            else passes++;
            tick();
            idle();
            checks++;
            if ({bus.ex_ALUsrc, bus.ex_ALUop} !== vecs[i].bundle[8:6])
                $display("FAIL decode_%s ex: got %b expected %b", vecs[i].name,
                         {bus.ex_ALUsrc, bus.ex_ALUop}, vecs[i].bundle[8:6]);
            else passes++;
            tick();
            checks++;
            if ({bus.mem_memRead, bus.mem_memWrite, bus.mem_branch, bus.mem_uncond} !== vecs[i].bundle[5:2])
                $display("FAIL decode_%s mem: got %b expected %b", vecs[i].name,
                         {bus.mem_memRead, bus.mem_memWrite, bus.mem_branch, bus.mem_uncond},
                         vecs[i].bundle[5:2]);
            else passes++;
            tick();
            checks++;
            if ({bus.wb_memtoReg, bus.wb_regWrite} !== vecs[i].bundle[1:0])
                $display("FAIL decode_%s wb: got %b expected %b", vecs[i].name,
                         {bus.wb_memtoReg, bus.wb_regWrite}, vecs[i].bundle[1:0]);
            else passes++;
            if (!vecs[i].ill) begin
                checks++;
                if (bus.wb_rd !== rd)
                    $display("FAIL decode_%s wb_rd: got %0d expected %0d", vecs[i].name, bus.wb_rd, rd);
                else passes++;
            end
        end
        // The same illegal opcode is not flagged when the slot is empty.
        drive(1'b0, BAD, 5'd1, 5'd2, 5'd3);
        #1;
        checks++;
        if ({bus.illegal_out, bus.id_reg2Loc} !== 2'b00)
            $display("FAIL decode_invalid_slot: got %b expected 00", {bus.illegal_out, bus.id_reg2Loc});
        else passes++;
        drive(1'b0, LDUR, 5'd1, 5'd2, 5'd3);
        tick();
        checks++;
        if ({bus.ex_ALUsrc, bus.ex_ALUop} !== 3'b000)
            $display("FAIL bubble_invalid_ldur ex: got %b expected 000", {bus.ex_ALUsrc, bus.ex_ALUop});
        else passes++;
        idle();
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, ADD, 5'd1, 5'd2, 5'd3);
        tick();
        checks++;
        if ({bus.ex_ALUsrc, bus.ex_ALUop} !== 3'b010)
            $display("FAIL b2b_add_ex: got %b expected 010", {bus.ex_ALUsrc, bus.ex_ALUop});
        else passes++;
        drive(1'b1, LDUR, 5'd3, 5'd0, 5'd4);
        tick();
        idle();
        checks++;
        if ({bus.ex_ALUsrc, bus.ex_ALUop} !== 3'b100)
            $display("FAIL b2b_ldur_ex: got %b expected 100", {bus.ex_ALUsrc, bus.ex_ALUop});
        else passes++;
        tick();
        checks++;
        if ({bus.wb_regWrite, bus.wb_memtoReg, bus.wb_rd} !== {2'b10, 5'd3})
            $display("FAIL b2b_add_wb: got %b expected %b", {bus.wb_regWrite, bus.wb_memtoReg, bus.wb_rd},
                     {2'b10, 5'd3});
        else passes++;
        checks++;
        if (bus.mem_memRead !== 1'b1)
            $display("FAIL b2b_ldur_mem: got %b expected 1", bus.mem_memRead);
        else passes++;
        tick();
        checks++;
        if ({bus.wb_regWrite, bus.wb_memtoReg, bus.wb_rd} !== {2'b11, 5'd4})
            $display("FAIL b2b_ldur_wb: got %b expected %b", {bus.wb_regWrite, bus.wb_memtoReg, bus.wb_rd},
                     {2'b11, 5'd4});
        else passes++;
        tick();
    endtask

    task automatic test_load_use_timing();
        drive(1'b1, LDUR, 5'd1, 5'd0, 5'd5);
        tick();
        drive(1'b1, ADD, 5'd5, 5'd2, 5'd6);
        #1;
        checks++;
        if (bus.stall_out !== STALL_EN)
            $display("FAIL loaduse_stall: got %b expected %b", bus.stall_out, STALL_EN);
        else passes++;
        tick();
        checks++;
        if (bus.mem_memRead !== 1'b1)
            $display("FAIL loaduse_ldur_mem: got %b expected 1", bus.mem_memRead);
        else passes++;
        if (STALL_EN) begin
            checks++;
            if ({bus.ex_ALUsrc, bus.ex_ALUop} !== 3'b000)
                $display("FAIL loaduse_bubble_ex: got %b expected 000", {bus.ex_ALUsrc, bus.ex_ALUop});
            else passes++;
            checks++;
            if (bus.stall_out !== 1'b0)
                $display("FAIL loaduse_stall_once: got %b expected 0", bus.stall_out);
            else passes++;
            tick();
        end
        idle();
        checks++;
        if ({bus.ex_ALUsrc, bus.ex_ALUop} !== 3'b010)
            $display("FAIL loaduse_add_ex: got %b expected 010", {bus.ex_ALUsrc, bus.ex_ALUop});
        else passes++;
        tick();
        tick();
        tick();
    endtask

    task automatic load_then(input logic [4:0] loadRd, input logic v, input logic [10:0] opc,
                             input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                             input logic hazard, input string name);
        drive(1'b1, LDUR, 5'd1, 5'd0, loadRd);
        tick();
        drive(v, opc, rn, rm, rd);
        #1;
        checks++;
        if (bus.stall_out !== (hazard & STALL_EN))
            $display("FAIL hazard_%s stall_out: got %b expected %b", name, bus.stall_out, hazard & STALL_EN);
        else passes++;
        tick();
        idle();
        tick();
        tick();
    endtask

    task automatic test_hazard_sources();
        load_then(5'd5,  1'b1, ADD,  5'd5, 5'd2, 5'd6, 1'b1, "rtype_rn");
        load_then(5'd5,  1'b1, SUB,  5'd2, 5'd5, 5'd6, 1'b1, "rtype_rm");
        load_then(5'd5,  1'b1, STUR, 5'd1, 5'd0, 5'd5, 1'b1, "stur_rt");
        load_then(5'd5,  1'b1, CBZ,  5'd0, 5'd0, 5'd5, 1'b1, "cbz_rt");
        load_then(5'd5,  1'b1, LDUR, 5'd5, 5'd0, 5'd6, 1'b1, "ldur_rn");
        load_then(5'd5,  1'b1, LDUR, 5'd2, 5'd5, 5'd6, 1'b0, "ldur_rm_unused");
        load_then(5'd5,  1'b1, CBZ,  5'd0, 5'd5, 5'd7, 1'b0, "cbz_rm_unused");
        load_then(5'd5,  1'b1, ADD,  5'd1, 5'd2, 5'd5, 1'b0, "rtype_rd_only");
        load_then(5'd5,  1'b1, BR,   5'd5, 5'd5, 5'd5, 1'b0, "b_no_sources");
        load_then(5'd5,  1'b0, ADD,  5'd5, 5'd5, 5'd6, 1'b0, "invalid_slot");
        load_then(5'd31, 1'b1, ADD,  5'd31, 5'd2, 5'd6, 1'b0, "xzr");
        // An ADD in EX (no memRead) never stalls a dependent reader.
        drive(1'b1, ADD, 5'd1, 5'd2, 5'd5);
        tick();
        drive(1'b1, ADD, 5'd5, 5'd5, 5'd6);
        #1;
        checks++;
        if (bus.stall_out !== 1'b0)
            $display("FAIL hazard_alu_producer stall_out: got %b expected 0", bus.stall_out);
        else passes++;
        idle();
        tick();
        tick();
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, CBZ, 5'd0, 5'd0, 5'd7);
        tick();
        drive(1'b1, LDUR, 5'd1, 5'd0, 5'd8);
        tick();
        checks++;
        if ({bus.mem_branch, bus.ex_ALUsrc} !== 2'b11)
            $display("FAIL flush_setup: got %b expected 11", {bus.mem_branch, bus.ex_ALUsrc});
        else passes++;
        drive(1'b1, STUR, 5'd2, 5'd0, 5'd9);
        bus.flush_in = 1'b1;
        tick();
        bus.flush_in = 1'b0;
        idle();
        checks++;
        if ({bus.ex_ALUsrc, bus.ex_ALUop, bus.mem_memRead, bus.mem_memWrite, bus.mem_branch,
             bus.mem_uncond} !== 7'd0)
            $display("FAIL flush_ex_mem: got %b expected 0000000",
                     {bus.ex_ALUsrc, bus.ex_ALUop, bus.mem_memRead, bus.mem_memWrite, bus.mem_branch,
                      bus.mem_uncond});
        else passes++;
        checks++;
        if ({bus.wb_regWrite, bus.wb_memtoReg, bus.wb_rd} !== {2'b00, 5'd7})
            $display("FAIL flush_wb_cbz: got %b expected %b", {bus.wb_regWrite, bus.wb_memtoReg, bus.wb_rd},
                     {2'b00, 5'd7});
        else passes++;
        tick();
        checks++;
        if ({bus.wb_regWrite, bus.wb_memtoReg, bus.wb_rd} !== 7'd0)
            $display("FAIL flush_wb_squashed_ldur: got %b expected 0000000",
                     {bus.wb_regWrite, bus.wb_memtoReg, bus.wb_rd});
        else passes++;
        tick();
        // Flush wins over a simultaneous load-use hazard.
        drive(1'b1, LDUR, 5'd1, 5'd0, 5'd5);
        tick();
        drive(1'b1, ADD, 5'd5, 5'd2, 5'd6);
        bus.flush_in = 1'b1;
        #1;
        checks++;
        if (bus.stall_out !== 1'b0)
            $display("FAIL flush_over_stall stall_out: got %b expected 0", bus.stall_out);
        else passes++;
        tick();
        bus.flush_in = 1'b0;
        idle();
        checks++;
        if ({bus.ex_ALUop, bus.mem_memRead} !== 3'b000)
            $display("FAIL flush_over_stall ex_mem: got %b expected 000", {bus.ex_ALUop, bus.mem_memRead});
        else passes++;
        tick();
        tick();
    endtask

    task automatic test_reset_midstream();
        logic [13:0] got;
        drive(1'b1, LDUR, 5'd1, 5'd0, 5'd4);
        tick();
        tick();
        tick();
        checks++;
        if ({bus.ex_ALUsrc, bus.mem_memRead, bus.wb_regWrite, bus.wb_rd} !== {3'b111, 5'd4})
            $display("FAIL midreset_setup: got %b expected %b",
                     {bus.ex_ALUsrc, bus.mem_memRead, bus.wb_regWrite, bus.wb_rd}, {3'b111, 5'd4});
        else passes++;
        #1;
        reset = 1'b1;
        #1;
        got = {bus.ex_ALUsrc, bus.ex_ALUop, bus.mem_memRead, bus.mem_memWrite, bus.mem_branch,
               bus.mem_uncond, bus.wb_memtoReg, bus.wb_regWrite, bus.wb_rd};
        checks++;
        if (got !== 14'd0) $display("FAIL midreset_async_clear: got %b expected %b", got, 14'd0);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, ADD, 5'd1, 5'd2, 5'd3);
        tick();
        idle();
        checks++;
        if ({bus.ex_ALUsrc, bus.ex_ALUop, bus.mem_memRead} !== 4'b0100)
            $display("FAIL midreset_first_decode: got %b expected 0100",
                     {bus.ex_ALUsrc, bus.ex_ALUop, bus.mem_memRead});
        else passes++;
        tick();
        tick();
        tick();
    endtask

    initial begin
        checks       = 0;
        passes       = 0;
        reset        = 1'b1;
        bus.flush_in = 1'b0;
        idle();
        #1;
        test_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        test_decode();
        test_back_to_back();
        test_load_use_timing();
        test_hazard_sources();
        test_flush();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
